// File: rtl/fpu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_issue_ctrl
//   Initiator side of the FPU operation interface. Commands from the bus-side
//   slave are buffered in a small FIFO and issued to the FPU one at a time.
//   Operands and enable are held stable until fpu_data_valid. The result is
//   then returned on a valid/ready response port. An illegal select code or
//   an FPU that never answers produces an error response.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   cmd_*                 command push port (valid/ready, op1, op2, sel)
//   rsp_*                 response port (valid/ready, result, err)
//   fpu_*                 FPU core interface (operands, select, enable,
//                         result, data_valid)
//   busy                  FSM not idle or commands still queued
//   cmd_count             FIFO occupancy, 0..DEPTH
//
// States
//   IDLE | waiting for a queued command; pops the FIFO head when one exists
//   EXEC | fpu_enable high, operands held, waiting for data_valid or timeout
//   RESP | response presented on rsp_*, waiting for rsp_ready
// ---------------------------------------------------------------------------
module fpu_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [31:0]                  cmd_op1,
  input  logic [31:0]                  cmd_op2,
  input  logic [2:0]                   cmd_sel,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [31:0]                  rsp_result,
  output logic                         rsp_err,
  output logic [31:0]                  fpu_op1,
  output logic [31:0]                  fpu_op2,
  output logic [2:0]                   fpu_op_select,
  output logic                         fpu_enable,
  input  logic [31:0]                  fpu_result,
  input  logic                         fpu_data_valid,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   cmd_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  sel;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  cmd_t          fifo_q [DEPTH];
  cmd_t          fifo_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  cmd_t          cur_q, cur_d;
  logic [31:0]   result_q, result_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic push;
  logic pop;
  cmd_t head;

  // Ready comes only from the registered count, so a full FIFO never accepts
  // even if a pop happens in the same cycle.
  assign cmd_ready = (count_q != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign head      = fifo_q[rd_ptr_q];

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    cur_d    = cur_q;
    result_d = result_q;
    err_d    = err_q;
    tmo_d    = tmo_q;

    if (push) begin
      fifo_d[wr_ptr_q].op1 = cmd_op1;
      fifo_d[wr_ptr_q].op2 = cmd_op2;
      fifo_d[wr_ptr_q].sel = cmd_sel;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          cur_d = head;
          if (head.sel <= 3'd2) begin
            state_d = EXEC;
            tmo_d   = '0;
          end else begin
            // Illegal select: answer immediately, the FPU is never enabled.
            state_d  = RESP;
            result_d = '0;
            err_d    = 1'b1;
          end
        end
      end
      EXEC: begin
        // data_valid is checked first so it wins over a coincident expiry.
        if (fpu_data_valid) begin
          state_d  = RESP;
          result_d = fpu_result;
          err_d    = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          state_d  = RESP;
          result_d = QNAN;
          err_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q   <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      cur_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cur_q    <= cur_d;
      result_q <= result_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign fpu_enable    = (state_q == EXEC);
  assign fpu_op1       = cur_q.op1;
  assign fpu_op2       = cur_q.op2;
  assign fpu_op_select = cur_q.sel;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_result    = result_q;
  assign rsp_err       = err_q;
  assign busy          = (state_q != IDLE) || (count_q != '0);
  assign cmd_count     = count_q;

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Initiator side of the FPU operation interface (OP1/OP2/OP_select/enable in, Result/data_valid out).
- Buffers floating-point commands from a bus-side slave in a small FIFO and issues them one at a time to the FPU.
- Holds enable and operands stable until data_valid, captures Result, and returns it through a valid/ready response port with a timeout and illegal-op error flag.
- Sits between the APB register slave and the FPU core.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2).
- TIMEOUT, 64, max EXEC cycles waiting for fpu_data_valid before error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (= not full)
- cmd_op1  in  32  operand 1 (IEEE-754 single)
- cmd_op2  in  32  operand 2
- cmd_sel  in  3  000 add, 001 sub, 010 mult, others illegal
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_result  out  32  captured result
- rsp_err  out  1  1 = illegal op or timeout
- fpu_op1  out  32  to FPU OP1
- fpu_op2  out  32  to FPU OP2
- fpu_op_select  out  3  to FPU OP_select
- fpu_enable  out  1  to FPU enable
- fpu_result  in  32  from FPU Result
- fpu_data_valid  in  1  from FPU data_valid
- busy  out  1  FSM not IDLE or FIFO non-empty
- cmd_count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Single clock domain: all state updates on the rising edge of clk.
- Reset (synchronous, rst=1 at an edge) is valid at any point, including mid-operation:
  - FIFO emptied; FSM to IDLE; timeout counter cleared.
  - Outputs after the edge: cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_err=0, fpu_enable=0, fpu_op1/op2=0, fpu_op_select=0, busy=0, cmd_count=0.
  - An in-flight FPU operation is abandoned; its late data_valid is ignored.
- FIFO:
  - Push on cmd_valid && cmd_ready.
  - cmd_ready = (cmd_count != DEPTH), driven combinationally from registered count only; no same-cycle bypass when full.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If the FIFO is non-empty at an edge, pop the head into the operand/select registers.
  - Legal sel → EXEC with timeout counter=0.
  - Illegal sel → RESP with rsp_err=1 and rsp_result=0; the FPU is never enabled.
  - No bypass: a command pushed at edge t is popped at edge t+1 at the earliest.
- EXEC:
  - fpu_enable=1; fpu_op1/op2/op_select driven from the registers and held stable for the whole state.
  - Counter increments each cycle.
  - fpu_data_valid=1 → capture fpu_result into rsp_result, rsp_err=0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT-1 → rsp_result=32'h7FC00000 (qNaN), rsp_err=1, go to RESP.
  - If data_valid and expiry coincide, data_valid wins.
- RESP:
  - fpu_enable=0; rsp_valid=1; rsp_result and rsp_err held stable.
  - rsp_ready=1 → IDLE at that edge.
  - The earliest next enable is 2 cycles later, so the FPU always sees enable low for at least 1 cycle between operations.
- fpu_data_valid is ignored outside EXEC.
- Latency, empty FIFO, FPU valid k cycles after enable rises, rsp_ready tied high:
  - push at edge t; enable high after edge t+1; rsp_valid high after edge t+1+k.
- Throughput: one operation per (k+2) cycles minimum.
- cmd_count ranges 0..DEPTH; never over- or underflows.

Test Plan:
- Reset, then push add 3F800000 + 40000000 with the FPU model returning 40400000 after 3 cycles → fpu_enable high for 3 cycles with stable operands; rsp_result=40400000, rsp_err=0.
- Push 5 commands back-to-back with DEPTH=4 while the FPU is stalled → first popped, 4 queued; cmd_ready=0 at cmd_count=4; all 5 responses delivered in order.
- cmd_sel=3'b111 → no fpu_enable pulse; rsp_valid with rsp_err=1, rsp_result=0; the next legal command proceeds normally.
- FPU model never asserts valid → after exactly 64 EXEC cycles rsp_err=1, rsp_result=7FC00000.
- rsp_ready held low 10 cycles with 2 commands queued → rsp_result stable, fpu_enable=0, second op not issued until the handshake; enable low ≥1 cycle between ops.
- rst asserted mid-EXEC with 3 queued → next cycle fpu_enable=0, cmd_count=0, rsp_valid=0; a late fpu_data_valid produces no response.
